// File: rtl/hazard_pkg.sv
// Shared decode constants, multdiv FSM states and the FD read-set helper for hazard_ctrl.
package hazard_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;

    localparam logic [4:0] ALU_MULT = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

    typedef struct packed {
        logic uses_rs;
        logic uses_rt;
        logic uses_rd;
    } read_set_t;

    function automatic read_set_t read_set(input logic [4:0] op);
        read_set_t rs_set;
        rs_set.uses_rs = !(op == OP_J || op == OP_JAL || op == OP_SETX);
        rs_set.uses_rt = (op == OP_RTYPE);
        rs_set.uses_rd = (op == OP_SW || op == OP_BNE || op == OP_JR || op == OP_BLT);
        return rs_set;
    endfunction

    function automatic logic writes_reg(input logic [4:0] op);
        return (op == OP_RTYPE || op == OP_ADDI || op == OP_LW);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-latch instructions in, stall / multdiv control out, plus the tracker state for debug.
interface hazard_ctrl_if
    import hazard_pkg::*;
#(
    parameter int IW = 32,
    parameter int RW = 5
);
    logic [IW-1:0] fd_ir;
    logic [IW-1:0] dx_ir;
    logic [IW-1:0] xm_ir;
    logic          stall;
    logic          md_start;
    logic          md_is_div;
    logic          md_busy;
    logic          md_wb_valid;
    logic [RW-1:0] md_wb_rd;
    md_state_t     md_state;

    modport master (
        output fd_ir, dx_ir, xm_ir,
        input  stall, md_start, md_is_div, md_busy, md_wb_valid, md_wb_rd, md_state
    );

    modport slave (
        input  fd_ir, dx_ir, xm_ir,
        output stall, md_start, md_is_div, md_busy, md_wb_valid, md_wb_rd, md_state
    );
endinterface

// File: rtl/hazard_ctrl_md_tracker.sv
// md_tracker: IDLE/BUSY/DONE FSM with latency down-counter and destination latch for one multdiv op.
module md_tracker
    import hazard_pkg::*;
#(
    parameter int RW          = 5,
    parameter int MULT_CYCLES = 17,
    parameter int DIV_CYCLES  = 33
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_start,
    input  logic          i_is_div,
    input  logic [RW-1:0] i_dest,
    output md_state_t     o_state,
    output logic [RW-1:0] o_dest
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    md_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic [RW-1:0] r_dest;
    md_state_t     w_state_nx;
    logic [CW-1:0] w_cnt_nx;
    logic [RW-1:0] w_dest_nx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dest  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_dest  <= w_dest_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_dest_nx  = r_dest;
        case (r_state)
            IDLE, DONE: begin
                // DONE falls back to IDLE unless a new op is issued back-to-back
                w_state_nx = IDLE;
                if (i_start) begin
                    w_state_nx = BUSY;
                    w_cnt_nx   = i_is_div ? DIV_LOAD : MULT_LOAD;
                    w_dest_nx  = i_dest;
                end
            end
            BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nx = DONE;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign o_state = r_state;
    assign o_dest  = r_dest;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / multdiv hazard detection and single stall output.
// Build option MULTDIV_OVERLAP_EN lets independent instructions flow while a multdiv op is in flight.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int IW          = 32,
    parameter int NREG        = 32,
    parameter int MULT_CYCLES = 17,
    parameter int DIV_CYCLES  = 33
) (
    input logic         clock,
    input logic         reset,
    hazard_ctrl_if.slave bus
);
    localparam int RW = $clog2(NREG);

    logic [4:0]    w_fd_op, w_dx_op, w_xm_op, w_fd_alu, w_dx_alu;
    logic [RW-1:0] w_fd_rd, w_fd_rs, w_fd_rt, w_dx_rd;
    read_set_t     w_fd_set;
    logic          w_fd_md, w_dx_md, w_dx_div;
    logic          w_lu_hit, w_load_use, w_md_start, w_stall;
    md_state_t     w_state;
    logic [RW-1:0] w_dest;
    logic          w_busy, w_done;

    assign w_fd_op  = bus.fd_ir[31:27];
    assign w_dx_op  = bus.dx_ir[31:27];
    assign w_xm_op  = bus.xm_ir[31:27];
    assign w_fd_alu = bus.fd_ir[6:2];
    assign w_dx_alu = bus.dx_ir[6:2];
    assign w_fd_rd  = bus.fd_ir[22 +: RW];
    assign w_fd_rs  = bus.fd_ir[17 +: RW];
    assign w_fd_rt  = bus.fd_ir[12 +: RW];
    assign w_dx_rd  = bus.dx_ir[22 +: RW];
    assign w_fd_set = read_set(w_fd_op);

    assign w_fd_md  = (w_fd_op == OP_RTYPE) && (w_fd_alu == ALU_MULT || w_fd_alu == ALU_DIV);
    assign w_dx_md  = (w_dx_op == OP_RTYPE) && (w_dx_alu == ALU_MULT || w_dx_alu == ALU_DIV);
    assign w_dx_div = (w_dx_op == OP_RTYPE) && (w_dx_alu == ALU_DIV);

    assign w_lu_hit   = (w_fd_set.uses_rs && w_fd_rs == w_dx_rd)
                     || (w_fd_set.uses_rt && w_fd_rt == w_dx_rd)
                     || (w_fd_set.uses_rd && w_fd_rd == w_dx_rd);
    assign w_load_use = (w_dx_op == OP_LW) && (w_dx_rd != '0) && w_lu_hit;

    assign w_md_start = w_dx_md && (w_state != BUSY);
    assign w_busy     = (w_state != IDLE);
    assign w_done     = (w_state == DONE);

    md_tracker #(
        .RW          (RW),
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_tracker (
        .clock    (clock),
        .reset    (reset),
        .i_start  (w_md_start),
        .i_is_div (w_dx_div),
        .i_dest   (w_dx_rd),
        .o_state  (w_state),
        .o_dest   (w_dest)
    );

`ifdef MULTDIV_OVERLAP_EN
    logic w_in_busy, w_sb_hit, w_struct, w_raw_waw, w_wb_col;
    // Scoreboard terms look at BUSY only: in DONE the result is on the writeback port, so a
    // dependent instruction is released unless XM also wants that port.
    assign w_in_busy = (w_state == BUSY);
    assign w_sb_hit  = (w_fd_set.uses_rs && w_fd_rs == w_dest)
                    || (w_fd_set.uses_rt && w_fd_rt == w_dest)
                    || (w_fd_set.uses_rd && w_fd_rd == w_dest)
                    || (w_fd_rd == w_dest);
    assign w_struct  = w_fd_md && (w_in_busy || w_dx_md);
    assign w_raw_waw = w_in_busy && (w_dest != '0) && w_sb_hit;
    assign w_wb_col  = w_done && writes_reg(w_xm_op);
    assign w_stall   = w_load_use || w_struct || w_raw_waw || w_wb_col;
`else
    assign w_stall   = w_load_use || w_busy || w_dx_md;
`endif

    assign bus.stall       = !reset && w_stall;
    assign bus.md_start    = !reset && w_md_start;
    assign bus.md_is_div   = !reset && w_md_start && w_dx_div;
    assign bus.md_busy     = w_busy;
    assign bus.md_wb_valid = w_done;
    assign bus.md_wb_rd    = w_done ? w_dest : '0;
    assign bus.md_state    = w_state;

    logic [IW-1:0] w_unused_ir;
    logic          w_unused;
    assign w_unused_ir = bus.fd_ir ^ bus.dx_ir ^ bus.xm_ir;
    assign w_unused    = ^{w_unused_ir, w_dest, w_xm_op, w_done, w_fd_md};
endmodule
